// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTRUCTION   = 32'h0000_0013;
  localparam logic [31:0] INSTRUCTION_BYTES = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WAIT_RESP,
    DRAIN,
    HALT
  } fetch_state_t;

  // One fetched word together with the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {pc, instruction} queue between fetch and decode.
// The head entry is a register so decode sees stable, glitch-free outputs.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t head_q;
  fetch_entry_t tail_q;
  logic [1:0]   count_q;
  logic         push_ok;
  logic         pop_ok;
  logic         tail_write;

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign pop_ok     = pop && (count_q != 2'd0);
  assign push_ok    = push && ((count_q != 2'd2) || pop_ok);
  assign tail_write = push_ok && ((!pop_ok && (count_q == 2'd1)) ||
                                  (pop_ok && (count_q == 2'd2)));

  // Head register and occupancy; flush wins over any push or pop.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      count_q <= 2'd0;
      head_q  <= '{pc: 32'h0000_0000, instruction: NOP_INSTRUCTION};
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_entry;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: head_q <= (count_q == 2'd2) ? tail_q : push_entry;
        default: ;
      endcase
    end
  end

  // Second entry holds data only; it is never visible until it has been written.
  always_ff @(posedge clock) begin
    // NOTE: storage with no reset-visible effect is left unreset; occupancy alone marks it valid.
    if (tail_write) tail_q <= push_entry;
  end

  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding word
// request at a time, buffers responses for decode and handles redirects.
// Optional build macro FETCH_MISALIGN_CHECK_EN: misaligned redirects set a
// sticky flag and halt fetch; without it the low target bits are cleared.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int          BUFFER_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        next_pc_valid,
  input  logic [31:0] next_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instruction_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  input  logic        decode_ready,
  output logic        fetch_misaligned
);

  localparam logic [1:0] CAPACITY = BUFFER_DEPTH[1:0];

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  req_pc_q;
  logic         misaligned_q;
  logic [31:0]  redirect_target;
  logic         redirect_misaligned;
  logic         req_accept;
  logic         push;
  logic         pop;
  logic         outstanding;
  logic [1:0]   count;
  logic [1:0]   count_after_push;
  fetch_entry_t head;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_target     = next_pc;
  assign redirect_misaligned = next_pc_valid && (next_pc[1:0] != 2'b00);
`else
  assign redirect_target     = next_pc & ~32'h0000_0003;
  assign redirect_misaligned = 1'b0;
`endif

  assign req_accept = (state_q == REQUEST) && imem_req_ready;
  assign push       = (state_q == WAIT_RESP) && imem_resp_valid && !next_pc_valid;
  assign pop        = instruction_valid && decode_ready && !next_pc_valid;

  // A response is still owed after this cycle if one was just accepted or is pending.
  assign outstanding = req_accept ||
                       (((state_q == WAIT_RESP) || (state_q == DRAIN)) && !imem_resp_valid);
  assign count_after_push = count + 2'd1 - {1'b0, pop};

  // Next-state selection; a redirect overrides normal sequencing.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    if (next_pc_valid && (state_q != HALT)) begin
      if (outstanding)                                 state_d = DRAIN;
      else if (misaligned_q || redirect_misaligned)    state_d = HALT;
      else                                             state_d = REQUEST;
    end else begin
      case (state_q)
        IDLE:      if (count < CAPACITY) state_d = REQUEST;
        REQUEST:   if (imem_req_ready)   state_d = WAIT_RESP;
        WAIT_RESP: if (imem_resp_valid)
                     state_d = (count_after_push < CAPACITY) ? REQUEST : IDLE;
        DRAIN:     if (imem_resp_valid)
                     state_d = misaligned_q ? HALT : REQUEST;
        HALT:      state_d = HALT;
        default:   state_d = IDLE;
      endcase
    end
  end

  // State, fetch PC, in-flight request PC and sticky misalignment flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (next_pc_valid)   fetch_pc_q <= redirect_target;
      else if (req_accept) fetch_pc_q <= fetch_pc_q + INSTRUCTION_BYTES;
      if (req_accept)          req_pc_q     <= fetch_pc_q;
      if (redirect_misaligned) misaligned_q <= 1'b1;
    end
  end

  fetch_buffer u_buffer (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry ('{pc: req_pc_q, instruction: imem_resp_data}),
    .pop        (pop),
    .flush      (next_pc_valid),
    .count      (count),
    .head       (head)
  );

  assign imem_req_valid    = (state_q == REQUEST);
  assign imem_req_addr     = fetch_pc_q;
  assign instruction_valid = (count != 2'd0);
  assign instruction       = head.instruction;
  assign pc                = head.pc;
  assign fetch_misaligned  = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency instruction memory.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        next_pc_valid = 1'b0;
  logic [31:0] next_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        instruction_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        decode_ready = 1'b1;
  logic        fetch_misaligned;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] req_log[$];
  logic [31:0] out_pc_log[$];
  logic [31:0] out_ins_log[$];

  fetch_unit dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .next_pc_valid     (next_pc_valid),
    .next_pc           (next_pc),
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_req_addr     (imem_req_addr),
    .imem_resp_valid   (imem_resp_valid),
    .imem_resp_data    (imem_resp_data),
    .instruction_valid (instruction_valid),
    .instruction       (instruction),
    .pc                (pc),
    .decode_ready      (decode_ready),
    .fetch_misaligned  (fetch_misaligned)
  );

  always #5 clock = ~clock;

  // Memory contents as a function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: log handshakes due at the next rising edge,
  // then answer an accepted request one cycle later.
  task automatic step();
    logic        accept;
    logic [31:0] addr;
    accept = imem_req_valid && imem_req_ready;
    addr   = imem_req_addr;
    if (accept) req_log.push_back(addr);
    if (instruction_valid && decode_ready && !next_pc_valid) begin
      out_pc_log.push_back(pc);
      out_ins_log.push_back(instruction);
    end
    @(negedge clock);
    imem_resp_valid = accept;
    imem_resp_data  = accept ? mem_word(addr) : 32'h0;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic redirect(input logic [31:0] target);
    next_pc_valid = 1'b1;
    next_pc       = target;
    step();
    next_pc_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
    check({tag, "_req_addr"},  imem_req_addr, DEFAULT_RESET_PC);
    check({tag, "_ivalid"},    32'(instruction_valid), 32'h0);
    check({tag, "_instr"},     instruction, 32'h0000_0013);
    check({tag, "_pc"},        pc, 32'h0);
    check({tag, "_misalign"},  32'(fetch_misaligned), 32'h0);
  endtask

  task automatic apply_reset(input bit check_values);
    @(negedge clock);
    reset_n         = 1'b0;
    imem_resp_valid = 1'b0;
    next_pc_valid   = 1'b0;
    repeat (2) @(negedge clock);
    if (check_values) check_reset_values("reset");
    reset_n = 1'b1;
    req_log.delete();
    out_pc_log.delete();
    out_ins_log.delete();
  endtask

  initial begin
    // Streaming fetch with decode always ready.
    apply_reset(1'b1);
    step();
    check("t1_n1_req_valid", 32'(imem_req_valid), 32'h1);
    check("t1_n1_req_addr", imem_req_addr, 32'h0);
    check("t1_n1_ivalid", 32'(instruction_valid), 32'h0);
    step();
    check("t1_n2_wait_no_req", 32'(imem_req_valid), 32'h0);
    step();
    check("t1_n3_ivalid", 32'(instruction_valid), 32'h1);
    check("t1_n3_pc", pc, 32'h0);
    check("t1_n3_instr", instruction, 32'hC0DE_0003);
    check("t1_n3_req_addr", imem_req_addr, 32'h4);
    steps(2);
    check("t1_n5_pc", pc, 32'h4);
    check("t1_n5_req_addr", imem_req_addr, 32'h8);
    steps(2);
    check("t1_n7_pc", pc, 32'h8);

    // Decode stalled: queue fills with two words and requests stop.
    decode_ready = 1'b0;
    apply_reset(1'b0);
    steps(10);
    check("t2_req_count", 32'(req_log.size()), 32'd2);
    check("t2_req1_addr", req_log[1], 32'h4);
    check("t2_stalled_no_req", 32'(imem_req_valid), 32'h0);
    check("t2_head_valid", 32'(instruction_valid), 32'h1);
    check("t2_head_pc", pc, 32'h0);
    decode_ready = 1'b1;
    step();
    check("t2_second_pc", pc, 32'h4);
    check("t2_second_instr", instruction, 32'hC0DE_0007);
    steps(4);
    check("t2_delivered", 32'(out_pc_log.size()), 32'd3);
    check("t2_order1", out_pc_log[1], 32'h4);
    check("t2_order2", out_pc_log[2], 32'h8);
    check("t2_order2_instr", out_ins_log[2], 32'hC0DE_000B);

    // Redirect in the cycle the 0x8 request is accepted.
    apply_reset(1'b0);
    steps(5);
    check("t3_pre_addr", imem_req_addr, 32'h8);
    redirect(32'h0000_0100);
    check("t3_drain_no_req", 32'(imem_req_valid), 32'h0);
    check("t3_flushed", 32'(instruction_valid), 32'h0);
    step();
    check("t3_req_valid", 32'(imem_req_valid), 32'h1);
    check("t3_req_addr", imem_req_addr, 32'h100);
    check("t3_no_stale", 32'(instruction_valid), 32'h0);
    steps(2);
    check("t3_ivalid", 32'(instruction_valid), 32'h1);
    check("t3_pc", pc, 32'h100);
    check("t3_instr", instruction, 32'hC0DE_0103);
    step();
    check("t3_delivered", 32'(out_pc_log.size()), 32'd2);
    check("t3_after_redirect", out_pc_log[1], 32'h100);

    // Redirect to the top word; fetch address wraps to zero.
    apply_reset(1'b0);
    redirect(32'hFFFF_FFFC);
    check("t4_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    steps(2);
    check("t4_pc", pc, 32'hFFFF_FFFC);
    check("t4_instr", instruction, 32'h3F21_FFFF);
    check("t4_wrap_addr", imem_req_addr, 32'h0);
    check("t4_wrap_req", 32'(imem_req_valid), 32'h1);

    // Misaligned redirect target.
    apply_reset(1'b0);
    redirect(32'h0000_0102);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("t5_misalign_set", 32'(fetch_misaligned), 32'h1);
    check("t5_halt_no_req", 32'(imem_req_valid), 32'h0);
    steps(5);
    check("t5_halt_req_count", 32'(req_log.size()), 32'd0);
    check("t5_halt_ivalid", 32'(instruction_valid), 32'h0);
    check("t5_misalign_sticky", 32'(fetch_misaligned), 32'h1);
`else
    check("t5_misalign_tied", 32'(fetch_misaligned), 32'h0);
    check("t5_req_valid", 32'(imem_req_valid), 32'h1);
    check("t5_aligned_addr", imem_req_addr, 32'h100);
    steps(2);
    check("t5_pc", pc, 32'h100);
`endif

    // Reset while waiting for a response, then a late response arrives.
    apply_reset(1'b0);
    steps(2);
    check("t6_pre_addr", imem_req_addr, 32'h4);
    reset_n         = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    check_reset_values("t6_in_reset");
    @(negedge clock);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBADB_AD00;
    @(negedge clock);
    reset_n = 1'b1;
    req_log.delete();
    out_pc_log.delete();
    out_ins_log.delete();
    step();
    check("t6_ignored_ivalid", 32'(instruction_valid), 32'h0);
    check("t6_restart_req", 32'(imem_req_valid), 32'h1);
    check("t6_restart_addr", imem_req_addr, 32'h0);
    steps(2);
    check("t6_ivalid", 32'(instruction_valid), 32'h1);
    check("t6_pc", pc, 32'h0);
    check("t6_instr", instruction, 32'hC0DE_0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage, the other end of the next_pc redirect interface driven by execute. Holds the fetch PC and issues one-at-a-time word requests to instruction memory over a valid/ready request channel and a fixed-response channel. Buffers returned words in a 2-entry queue and presents {pc, instruction} to decode with a valid/ready handshake. On a redirect from execute it flushes the queue and discards any response still in flight.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
BUFFER_DEPTH, 2, queue entries (fixed at 2; other values unsupported)

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  asynchronous active-low reset
next_pc_valid  input  1  redirect strobe from execute
next_pc  input  32  redirect target
imem_req_valid  output  1  request to instruction memory
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word address requested
imem_resp_valid  input  1  response data valid (1+ cycles after accept)
imem_resp_data  input  32  fetched instruction word
instruction_valid  output  1  queue head valid to decode
instruction  output  32  queue head instruction
pc  output  32  queue head PC
decode_ready  input  1  decode consumes head
fetch_misaligned  output  1  sticky misaligned-redirect flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state IDLE, fetch_pc=RESET_PC, queue empty, imem_req_valid=0, imem_req_addr=RESET_PC, instruction_valid=0, instruction=32'h0000_0013 (NOP), pc=0, fetch_misaligned=0. Reset mid-operation drops all state; any later response from the old request is not captured, because state is IDLE.
- States: IDLE, REQUEST, WAIT_RESP, DRAIN, HALT.
- IDLE -> REQUEST when occupancy < 2.
- REQUEST: imem_req_valid=1, imem_req_addr=fetch_pc. On imem_req_ready: record req_pc=fetch_pc, fetch_pc+=4 (modulo 2^32, 0xFFFF_FFFC wraps to 0), go WAIT_RESP. Valid and addr are held stable until accepted unless a redirect occurs.
- WAIT_RESP: on imem_resp_valid, push {req_pc, imem_resp_data}. Next state is REQUEST if post-push occupancy < 2, else IDLE.
- At most one outstanding request. Issue is allowed only when occupancy + outstanding < 2, so a push never overflows.
- Queue: instruction_valid = not empty; head is registered. Pop when instruction_valid && decode_ready. Push and pop may occur in the same cycle. Response-to-instruction_valid latency is 1 cycle.
- Redirect (next_pc_valid=1) has priority over everything:
  - Queue is flushed, so instruction_valid=0 next cycle, and any same-cycle pop or push is ignored.
  - fetch_pc <= next_pc.
  - If a request is outstanding (WAIT_RESP, or REQUEST accepted this cycle), go DRAIN. Otherwise go REQUEST.
  - In REQUEST without ready, imem_req_valid stays 1 and the address changes next cycle.
- DRAIN: next imem_resp_valid is discarded, then go REQUEST. A redirect during DRAIN updates fetch_pc and stays in DRAIN.
- Redirect latency with zero-wait memory: redirect cycle N, request at N+1, response at N+2, instruction_valid with pc=next_pc at N+3.
- Back-to-back redirects: the last one wins.

Optional Feature:
Macro FETCH_MISALIGN_CHECK_EN.
- Defined: a redirect with next_pc[1:0]!=0 sets fetch_misaligned=1 (sticky until reset), flushes the queue, and enters HALT. A pending response is still drained first. HALT never issues requests or asserts instruction_valid.
- Undefined: next_pc[1:0] is forced to 2'b00, fetch_misaligned is tied 0, and HALT is unreachable.

Decomposition:
- Package fetch_pkg: fetch_state_t enum, NOP_INSTRUCTION=32'h0000_0013, INSTRUCTION_BYTES=4, default RESET_PC.
- Sub-module fetch_buffer: 2-entry {pc, instruction} FIFO with push, pop, flush, count, and registered head. fetch_unit instantiates it once and owns the state machine.

Test Plan:
- Reset release, memory ready=1 with 1-cycle response, decode_ready=1 -> requests at addresses 0, 4, 8; instruction_valid at cycle 3 with pc=0; pcs increase by 4.
- decode_ready=0 for 10 cycles -> exactly 2 requests issued, queue holds pc 0 and 4, no further imem_req_valid; release -> in-order delivery with no loss.
- Redirect to 0x100 while a response for 0x8 is outstanding -> the 0x8 word is never presented; next instruction_valid has pc=0x100.
- Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> fetch_misaligned=1, no further requests. Without the macro, fetch proceeds at 0x100.
- Assert reset_n=0 during WAIT_RESP, then give a late resp_valid -> all outputs at reset values, response ignored, fetch restarts at RESET_PC.
